// File: rtl/ex_issue_stage_pkg.sv
// Shared definitions for the EX issue stage: decode-field bit positions,
// forwarding-source encodings and the forwarding hit test.
package ex_issue_stage_pkg;

  // Bit positions inside id_src_sel.
  localparam int unsigned SrcSelA = 0;  // 0: rs, 1: zero-extended shamt
  localparam int unsigned SrcSelB = 1;  // 0: rt, 1: immediate

  // Bit positions inside id_uses.
  localparam int unsigned UsesRs = 0;
  localparam int unsigned UsesRt = 1;

  // Forwarding source, MEM has priority over WB, WB over register data.
  typedef enum logic [1:0] {
    FwdReg = 2'd0,
    FwdWb  = 2'd1,
    FwdMem = 2'd2
  } fwd_sel_e;

  // A later stage supplies the operand only when it writes a real register ($0 never forwards).
  function automatic logic fwd_hit(input logic we, input logic [4:0] src_addr,
                                   input logic [4:0] dst_addr);
    return we && (src_addr == dst_addr) && (dst_addr != 5'd0);
  endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Bundle of everything crossing the EX issue stage boundary except clock and reset.
//   master: decode / MEM / WB / control side (drives id_*, flush, hold, forwarding sources)
//   slave : the issue stage itself (drives ALU operands, EX tags and id_stall)
interface ex_issue_stage_if;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [1:0]  id_uses;
  logic [1:0]  id_src_sel;
  logic [3:0]  id_aluop;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        hold;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        ex_valid;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [31:0] ex_store_data;
  logic        id_stall;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_uses, id_src_sel, id_aluop, id_reg_write, id_mem_read, flush, hold,
           mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
    input  alu_a, alu_b, alu_op, ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read,
           ex_store_data, id_stall
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_uses, id_src_sel, id_aluop, id_reg_write, id_mem_read, flush, hold,
           mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
    output alu_a, alu_b, alu_op, ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read,
           ex_store_data, id_stall
  );
endinterface

// File: rtl/ex_issue_stage_fwd_mux.sv
// Operand forwarding mux (fwd_mux): picks MEM result, WB result or the registered value.
//   i_addr       source register number held in EX
//   i_reg_data   registered operand value
//   i_mem_*      MEM-stage write port (enable, address, data)
//   i_wb_*       WB-stage write port (enable, address, data)
//   o_data       forwarded operand
module ex_issue_stage_fwd_mux
  import ex_issue_stage_pkg::*;
(
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_reg_data,
  input  logic        i_mem_we,
  input  logic [4:0]  i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_data
);

  fwd_sel_e w_sel;

  always_comb begin
    w_sel = FwdReg;
    if (fwd_hit(i_mem_we, i_addr, i_mem_addr)) begin
      w_sel = FwdMem;
    end else if (fwd_hit(i_wb_we, i_addr, i_wb_addr)) begin
      w_sel = FwdWb;
    end
  end

  always_comb begin
    case (w_sel)
      FwdMem:  o_data = i_mem_data;
      FwdWb:   o_data = i_wb_data;
      default: o_data = i_reg_data;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID->EX pipeline register with operand forwarding, load-use bubble insertion and hold.
//   clk, rst_n  clock and asynchronous active-low reset
//   io_bus      slave side of ex_issue_stage_if: id_* decode fields, flush/hold control,
//               MEM/WB forwarding sources in; ALU operands, EX tags, id_stall out
module ex_issue_stage
  import ex_issue_stage_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  ex_issue_stage_if.slave io_bus
);

  logic        r_valid;
  logic [4:0]  r_rs_addr;
  logic [4:0]  r_rt_addr;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_shamt;
  logic [1:0]  r_src_sel;
  logic [3:0]  r_alu_op;
  logic        r_reg_write;
  logic        r_mem_read;

  logic [31:0] w_rs_fwd;
  logic [31:0] w_rt_fwd;
  logic        w_load_use;
  logic        w_issue;

  ex_issue_stage_fwd_mux u_fwd_rs (
    .i_addr     (r_rs_addr),
    .i_reg_data (r_rs_data),
    .i_mem_we   (io_bus.mem_reg_write),
    .i_mem_addr (io_bus.mem_rd_addr),
    .i_mem_data (io_bus.mem_result),
    .i_wb_we    (io_bus.wb_reg_write),
    .i_wb_addr  (io_bus.wb_rd_addr),
    .i_wb_data  (io_bus.wb_result),
    .o_data     (w_rs_fwd)
  );

  ex_issue_stage_fwd_mux u_fwd_rt (
    .i_addr     (r_rt_addr),
    .i_reg_data (r_rt_data),
    .i_mem_we   (io_bus.mem_reg_write),
    .i_mem_addr (io_bus.mem_rd_addr),
    .i_mem_data (io_bus.mem_result),
    .i_wb_we    (io_bus.wb_reg_write),
    .i_wb_addr  (io_bus.wb_rd_addr),
    .i_wb_data  (io_bus.wb_result),
    .o_data     (w_rt_fwd)
  );

  // A load in EX cannot forward its data to the instruction right behind it.
  assign w_load_use = r_valid && r_mem_read && (r_rd_addr != 5'd0) && io_bus.id_valid &&
                      ((io_bus.id_uses[UsesRs] && (io_bus.id_rs_addr == r_rd_addr)) ||
                       (io_bus.id_uses[UsesRt] && (io_bus.id_rt_addr == r_rd_addr)));
  assign w_issue    = io_bus.id_valid && !w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
      r_src_sel   <= '0;
      r_alu_op    <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else begin
      if (io_bus.hold) begin
        // Tags freeze, but operands keep absorbing retiring writes so nothing is lost.
        r_rs_data <= w_rs_fwd;
        r_rt_data <= w_rt_fwd;
      end else begin
        r_valid     <= w_issue;
        r_rs_addr   <= io_bus.id_rs_addr;
        r_rt_addr   <= io_bus.id_rt_addr;
        r_rd_addr   <= io_bus.id_rd_addr;
        r_rs_data   <= io_bus.id_rs_data;
        r_rt_data   <= io_bus.id_rt_data;
        r_imm       <= io_bus.id_imm;
        r_shamt     <= io_bus.id_shamt;
        r_src_sel   <= io_bus.id_src_sel;
        r_alu_op    <= io_bus.id_aluop;
        r_reg_write <= w_issue && io_bus.id_reg_write;
        r_mem_read  <= w_issue && io_bus.id_mem_read;
      end
      if (io_bus.flush) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
      end
    end
  end

  assign io_bus.alu_a         = r_src_sel[SrcSelA] ? {27'd0, r_shamt} : w_rs_fwd;
  assign io_bus.alu_b         = r_src_sel[SrcSelB] ? r_imm : w_rt_fwd;
  assign io_bus.alu_op        = r_alu_op;
  assign io_bus.ex_valid      = r_valid;
  assign io_bus.ex_rd_addr    = r_rd_addr;
  assign io_bus.ex_reg_write  = r_reg_write;
  assign io_bus.ex_mem_read   = r_mem_read;
  assign io_bus.ex_store_data = w_rt_fwd;
  // hold may be high while in reset; stall must still read 0 then.
  assign io_bus.id_stall      = (w_load_use || io_bus.hold) && rst_n;

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  ex_issue_stage_if bus ();

  ex_issue_stage dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt;
    logic [1:0]  uses, src_sel;
    logic [3:0]  op;
    logic        rw, mr;
  } id_t;

  // Instruction sitting in EX as the architecture sees it.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic        rw, mr;
  } ex_t;

  ex_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic id_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rs_data, input logic [31:0] rt_data,
                             input logic [31:0] imm, input logic [4:0] shamt,
                             input logic [1:0] uses, input logic [1:0] src_sel,
                             input logic [3:0] op, input logic rw, input logic mr);
    id_t t;
    t.valid = 1'b1; t.rs = rs; t.rt = rt; t.rd = rd;
    t.rs_data = rs_data; t.rt_data = rt_data; t.imm = imm; t.shamt = shamt;
    t.uses = uses; t.src_sel = src_sel; t.op = op; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  task automatic drive_id(input id_t t);
    bus.id_valid = t.valid;     bus.id_rs_addr = t.rs;     bus.id_rt_addr = t.rt;
    bus.id_rd_addr = t.rd;      bus.id_rs_data = t.rs_data; bus.id_rt_data = t.rt_data;
    bus.id_imm = t.imm;         bus.id_shamt = t.shamt;    bus.id_uses = t.uses;
    bus.id_src_sel = t.src_sel; bus.id_aluop = t.op;       bus.id_reg_write = t.rw;
    bus.id_mem_read = t.mr;
  endtask

  task automatic clear_fwd();
    bus.mem_reg_write = 1'b0; bus.mem_rd_addr = 5'd0; bus.mem_result = 32'd0;
    bus.wb_reg_write = 1'b0;  bus.wb_rd_addr = 5'd0;  bus.wb_result = 32'd0;
  endtask

  task automatic idle_inputs();
    id_t t;
    t = mk(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
    t.valid = 1'b0;
    drive_id(t);
    clear_fwd();
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  // Value of register a as seen now: newest in-flight write wins, else the held value.
  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] v);
    if (a != 5'd0 && bus.mem_reg_write && bus.mem_rd_addr == a) return bus.mem_result;
    if (a != 5'd0 && bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_result;
    return v;
  endfunction

  function automatic logic m_load_use();
    if (!(m.valid && m.mr && m.rd != 5'd0 && bus.id_valid)) return 1'b0;
    return (bus.id_uses[0] && bus.id_rs_addr == m.rd) || (bus.id_uses[1] && bus.id_rt_addr == m.rd);
  endfunction

  task automatic m_reset();
    m = '{default: '0};
  endtask

  task automatic m_step();
    logic lu;
    logic [31:0] rsf, rtf;
    lu  = m_load_use();
    rsf = m_fwd(m.rs, m.rs_val);
    rtf = m_fwd(m.rt, m.rt_val);
    if (bus.hold) begin
      m.rs_val = rsf;
      m.rt_val = rtf;
    end else begin
      m.valid  = bus.id_valid && !lu;
      m.rs     = bus.id_rs_addr;  m.rt = bus.id_rt_addr; m.rd = bus.id_rd_addr;
      m.rs_val = bus.id_rs_data;  m.rt_val = bus.id_rt_data;
      m.imm    = bus.id_imm;      m.shamt = bus.id_shamt; m.sel = bus.id_src_sel;
      m.op     = bus.id_aluop;
      m.rw     = m.valid && bus.id_reg_write;
      m.mr     = m.valid && bus.id_mem_read;
    end
    if (bus.flush) begin
      m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ea, eb;
    chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m.valid});
    chk("ex_reg_write", {31'd0, bus.ex_reg_write}, {31'd0, m.rw});
    chk("ex_mem_read", {31'd0, bus.ex_mem_read}, {31'd0, m.mr});
    chk("id_stall", {31'd0, bus.id_stall}, {31'd0, rst_n && (m_load_use() || bus.hold)});
    if (m.valid) begin
      ea = m.sel[0] ? {27'd0, m.shamt} : m_fwd(m.rs, m.rs_val);
      eb = m.sel[1] ? m.imm : m_fwd(m.rt, m.rt_val);
      chk("alu_a", bus.alu_a, ea);
      chk("alu_b", bus.alu_b, eb);
      chk("store_data", bus.ex_store_data, m_fwd(m.rt, m.rt_val));
      chk("alu_op", {28'd0, bus.alu_op}, {28'd0, m.op});
      chk("ex_rd_addr", {27'd0, bus.ex_rd_addr}, {27'd0, m.rd});
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
    chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
    chk({tag, "_alu_op"}, {28'd0, bus.alu_op}, 32'd0);
    chk({tag, "_ex_valid"}, {31'd0, bus.ex_valid}, 32'd0);
    chk({tag, "_ex_rd"}, {27'd0, bus.ex_rd_addr}, 32'd0);
    chk({tag, "_ex_rw"}, {31'd0, bus.ex_reg_write}, 32'd0);
    chk({tag, "_ex_mr"}, {31'd0, bus.ex_mem_read}, 32'd0);
    chk({tag, "_store"}, bus.ex_store_data, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.id_stall}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_reset();
    idle_inputs();
    rst_n = 1'b0;
    // Junk on the inputs during reset must not leak out.
    bus.hold = 1'b1;
    drive_id(mk(5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 32'h9, 5'd4, 2'b11, 2'b11, 4'h5, 1'b1, 1'b1));
    #3 check_all_zero("reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Forwarding priority: MEM over WB over register data.
    drive_id(mk(5'd1, 5'd0, 5'd5, 32'd5, 32'd0, 32'd0, 5'd0, 2'b01, 2'b00, 4'h2, 1'b1, 1'b0));
    step();
    bus.id_valid = 1'b0;
    bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd1; bus.mem_result = 32'h10;
    bus.wb_reg_write = 1'b1;  bus.wb_rd_addr = 5'd1;  bus.wb_result = 32'h20;
    #1 chk("fwd_mem_over_wb", bus.alu_a, 32'h10);
    bus.mem_reg_write = 1'b0;
    #1 chk("fwd_wb_over_reg", bus.alu_a, 32'h20);
    bus.wb_reg_write = 1'b0;
    #1 chk("fwd_reg", bus.alu_a, 32'd5);
    chk("issue_op", {28'd0, bus.alu_op}, 32'h2);
    chk("issue_rd", {27'd0, bus.ex_rd_addr}, 32'd5);

    // $0 never forwards.
    @(negedge clk);
    drive_id(mk(5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b00, 4'h2, 1'b1, 1'b0));
    step();
    bus.id_valid = 1'b0;
    bus.wb_reg_write = 1'b1;  bus.wb_rd_addr = 5'd0;  bus.wb_result = 32'hFFFF_FFFF;
    bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd0; bus.mem_result = 32'hFFFF_FFFF;
    #1 chk("zero_reg_a", bus.alu_a, 32'd0);
    chk("zero_reg_store", bus.ex_store_data, 32'd0);

    // Load-use: lw $3 then add $7,$3,$1.
    @(negedge clk);
    clear_fwd();
    drive_id(mk(5'd2, 5'd0, 5'd3, 32'h100, 32'd0, 32'd4, 5'd0, 2'b01, 2'b10, 4'h0, 1'b1, 1'b1));
    step();
    drive_id(mk(5'd3, 5'd1, 5'd7, 32'hDEAD, 32'd1, 32'd0, 5'd0, 2'b11, 2'b00, 4'h2, 1'b1, 1'b0));
    #1 chk("lu_stall", {31'd0, bus.id_stall}, 32'd1);
    chk("lu_lw_valid", {31'd0, bus.ex_valid}, 32'd1);
    @(negedge clk);
    #1 chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    chk("lu_stall_released", {31'd0, bus.id_stall}, 32'd0);
    bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd3; bus.mem_result = 32'hABCD;
    step();
    bus.id_valid = 1'b0;
    clear_fwd();
    bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd3; bus.wb_result = 32'hABCD;
    #1 chk("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("lu_add_a", bus.alu_a, 32'hABCD);
    chk("lu_add_b", bus.alu_b, 32'd1);

    // Hold for three cycles while WB retires $4.
    @(negedge clk);
    clear_fwd();
    drive_id(mk(5'd0, 5'd4, 5'd8, 32'd0, 32'h11, 32'd0, 5'd0, 2'b10, 2'b00, 4'h3, 1'b1, 1'b0));
    step();
    bus.hold = 1'b1;
    bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd4; bus.wb_result = 32'h55;
    drive_id(mk(5'd1, 5'd1, 5'd9, 32'h77, 32'h77, 32'd0, 5'd0, 2'b11, 2'b00, 4'hF, 1'b1, 1'b0));
    #1 chk("hold_stall", {31'd0, bus.id_stall}, 32'd1);
    @(negedge clk);
    bus.wb_reg_write = 1'b0;
    #1 chk("hold_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("hold_op_frozen", {28'd0, bus.alu_op}, 32'h3);
    step();
    step();
    bus.hold = 1'b0;
    #1 chk("hold_alu_b", bus.alu_b, 32'h55);
    chk("hold_rd", {27'd0, bus.ex_rd_addr}, 32'd8);

    // Flush beats hold and load-use.
    @(negedge clk);
    clear_fwd();
    drive_id(mk(5'd2, 5'd0, 5'd3, 32'h100, 32'd0, 32'd4, 5'd0, 2'b01, 2'b10, 4'h0, 1'b1, 1'b1));
    step();
    drive_id(mk(5'd3, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 5'd0, 2'b01, 2'b00, 4'h2, 1'b1, 1'b0));
    bus.hold = 1'b1;
    bus.flush = 1'b1;
    #1 chk("flush_stall", {31'd0, bus.id_stall}, 32'd1);
    @(negedge clk);
    #1 chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    chk("flush_mr", {31'd0, bus.ex_mem_read}, 32'd0);
    bus.flush = 1'b0;
    bus.hold = 1'b0;

    // sll with shamt, then reset mid-hold.
    @(negedge clk);
    drive_id(mk(5'd0, 5'd2, 5'd10, 32'd0, 32'd1, 32'd0, 5'd7, 2'b10, 2'b01, 4'h4, 1'b1, 1'b0));
    step();
    #1 chk("sll_a", bus.alu_a, 32'd7);
    chk("sll_b", bus.alu_b, 32'd1);
    bus.hold = 1'b1;
    rst_n = 1'b0;
    #1 check_all_zero("midop_reset");
    drive_id(mk(5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 2'b00, 4'h9, 1'b1, 1'b0));
    bus.hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1 chk("post_reset_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("post_reset_op", {28'd0, bus.alu_op}, 32'h9);
    chk("post_reset_rd", {27'd0, bus.ex_rd_addr}, 32'd11);

    // Pin the model's forwarding rule to literal values.
    bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd2; bus.mem_result = 32'h77;
    bus.wb_reg_write = 1'b1;  bus.wb_rd_addr = 5'd2;  bus.wb_result = 32'h88;
    chk("model_pin_mem", m_fwd(5'd2, 32'd5), 32'h77);
    bus.mem_reg_write = 1'b0;
    chk("model_pin_wb", m_fwd(5'd2, 32'd5), 32'h88);
    chk("model_pin_other", m_fwd(5'd3, 32'd5), 32'd5);

    // Randomized run against the model.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1 m_reset();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bus.id_valid      = ($urandom_range(0, 4) != 0);
      bus.id_rs_addr    = 5'($urandom_range(0, 3));
      bus.id_rt_addr    = 5'($urandom_range(0, 3));
      bus.id_rd_addr    = 5'($urandom_range(0, 3));
      bus.id_rs_data    = $urandom;
      bus.id_rt_data    = $urandom;
      bus.id_imm        = $urandom;
      bus.id_shamt      = 5'($urandom_range(0, 31));
      bus.id_uses       = 2'($urandom_range(0, 3));
      bus.id_src_sel    = 2'($urandom_range(0, 3));
      bus.id_aluop      = 4'($urandom_range(0, 15));
      bus.id_reg_write  = ($urandom_range(0, 3) != 0);
      bus.id_mem_read   = ($urandom_range(0, 2) == 0);
      bus.flush         = ($urandom_range(0, 9) == 0);
      bus.hold          = ($urandom_range(0, 4) == 0);
      bus.mem_reg_write = ($urandom_range(0, 1) == 0);
      bus.mem_rd_addr   = 5'($urandom_range(0, 3));
      bus.mem_result    = $urandom;
      bus.wb_reg_write  = ($urandom_range(0, 1) == 0);
      bus.wb_rd_addr    = 5'($urandom_range(0, 3));
      bus.wb_result     = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1 m_reset();
        check_outputs();
        rst_n = 1'b1;
      end
      #1 check_outputs();
      @(posedge clk);
      m_step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 id_valid  in  1  decode slot holds an instruction.
REQ-004 id_rs_addr / id_rt_addr  in  5 each  source register numbers.
REQ-005 id_rd_addr  in  5  destination register number.
REQ-006 id_rs_data / id_rt_data  in  32 each  regfile read data.
REQ-007 id_imm  in  32  already-extended immediate.
REQ-008 id_shamt  in  5  shift amount field.
REQ-009 id_uses  in  2  bit0 rs read, bit1 rt read.
REQ-010 id_src_sel  in  2  bit0 A source (0 rs, 1 shamt); bit1 B source (0 rt, 1 imm).
REQ-011 id_aluop  in  4  ALUop.vh code.
REQ-012 id_reg_write / id_mem_read  in  1 each  decode control bits.
REQ-013 flush  in  1  kill the instruction being captured.
REQ-014 hold  in  1  downstream stall; freeze EX.
REQ-015 mem_reg_write, mem_rd_addr[5], mem_result[32]  in  MEM-stage forwarding source.
REQ-016 wb_reg_write, wb_rd_addr[5], wb_result[32]  in  WB-stage forwarding source.
REQ-017 alu_a / alu_b  out  32 each  ALU operands.
REQ-018 alu_op  out  4  registered ALUop.
REQ-019 ex_valid, ex_rd_addr[5], ex_reg_write, ex_mem_read  out  EX-stage tags.
REQ-020 ex_store_data  out  32  forwarded rt value.
REQ-021 id_stall  out  1  decode must hold its instruction.

Function
REQ-022 Pipeline register SHALL capture all id_* fields every clock unless hold=1 or a load-use bubble is inserted; latency ID->ALU operand one cycle.
REQ-023 Forwarding SHALL be combinational from registered rs/rt: MEM match wins over WB match, WB over register data; match = write enable, addr equal, addr != 0.
REQ-024 alu_a SHALL be zero-extended shamt when A-sel=1, else forwarded rs; alu_b SHALL be imm when B-sel=1, else forwarded rt; ex_store_data SHALL always be forwarded rt.
REQ-025 Load-use: when ex_valid, ex_mem_read, ex_rd_addr!=0, id_valid and a used id source equals ex_rd_addr, id_stall SHALL be 1 and next cycle ex_valid SHALL be 0 (bubble).
REQ-026 id_stall SHALL equal load-use OR hold.
REQ-027 hold=1: tags/op frozen, but rs/rt data registers SHALL reload with their forwarded values each cycle so WB retirement during hold loses no data.
REQ-028 flush=1 SHALL load ex_valid=0 next edge, overriding hold and load-use.
REQ-029 ex_reg_write and ex_mem_read SHALL be 0 whenever ex_valid=0.
REQ-030 id_valid=0 SHALL load a bubble.

Reset
REQ-031 rst_n low SHALL immediately clear ex_valid, ex_reg_write, ex_mem_read, alu_op, all data/address registers to 0; id_stall reads 0.
REQ-032 Reset mid-hold or mid-bubble SHALL discard the held instruction; first captured instruction after release is the id_* present then.

Structure
REQ-033 Source-select bit positions and forwarding-priority encodings SHALL be defines in a shared header next to ALUop.vh.
REQ-034 One sub-module fwd_mux (addr, regdata, mem/wb sources -> value) SHALL be instanced twice (rs, rt).

Verification
REQ-035 $1=5 in EX, MEM writes $1=0x10, WB writes $1=0x20 -> alu_a=0x10.
REQ-036 WB writes $0=0xFFFF_FFFF, op reads $0 -> alu_a=0.
REQ-037 lw $3 in EX, next add uses $3 -> id_stall=1 one cycle, then ex_valid=0, add issues with forwarded load data.
REQ-038 hold=1 three cycles while WB $4=0x55 retires in cycle 1 -> after release alu_b=0x55.
REQ-039 flush with hold and load-use asserted -> ex_valid=0, ex_reg_write=0 next cycle.
REQ-040 sll shamt=7, B-sel=0, $2=1 -> alu_a=7, alu_b=1; rst_n low mid-op -> all outputs 0 immediately.
